// File: rtl/vga_line_prefetch_pkg.sv
// Shared constants and types for the VGA line prefetcher and its line RAM.
package vga_pkg;

  localparam int H_ACTIVE       = 640;
  localparam int V_ACTIVE       = 480;
  localparam int WORDS_PER_LINE = 20;
  localparam int IDX_W          = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } prefetch_state_t;

endpackage

// File: rtl/vga_line_ram.sv
// Ping-pong pair of line buffers: one synchronous write port, one combinational read port.
module vga_line_ram
  import vga_pkg::*;
#(
  parameter int WORDS = WORDS_PER_LINE
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             we,
  input  logic             wr_bank,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic             rd_bank,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [2][WORDS];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < WORDS; w++) begin
          mem[b][w] <= '0;
        end
      end
    end else if (we && (int'(wr_idx) < WORDS)) begin
      mem[wr_bank][wr_idx] <= wr_data;
    end
  end

  // Indices past the end of a row read as blank pixels rather than aliasing.
  assign rd_data = (int'(rd_idx) < WORDS) ? mem[rd_bank][rd_idx] : '0;

endmodule

// File: rtl/vga_line_prefetch.sv
// Streams one framebuffer row from SRAM into the back line buffer while the
// front buffer feeds the scan-out pixel path.
module vga_line_prefetch #(
  parameter logic [31:0] BASE_ADDR      = 32'd0,
  parameter int          WORDS_PER_LINE = 20,
  parameter int          LINES          = 480
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        fetch_start,
  input  logic [8:0]  fetch_row,
  input  logic        swap,
  input  logic        rd_en,
  input  logic [9:0]  rd_x,
  input  logic [31:0] SRAM_data_in,
  input  logic        SRAM_busy,
  output logic [31:0] word_address_dest,
  output logic [3:0]  byte_select,
  output logic        data_en,
  output logic        pixel_data,
  output logic        fetch_busy,
  output logic        fetch_done,
  output logic        underrun,
  output logic        bad_row
);

  import vga_pkg::*;

  prefetch_state_t  state;
  logic [IDX_W-1:0] idx;
  logic             front_sel;
  logic             capture;
  logic             last_word;
  logic [31:0]      front_word;

  // A swap always wins over a capture on the same edge, so an aborted fetch
  // never writes into what has just become the front buffer.
  assign capture   = (state == FETCH) && data_en && !SRAM_busy && !swap;
  assign last_word = (int'(idx) == WORDS_PER_LINE - 1);

  vga_line_ram #(
    .WORDS(WORDS_PER_LINE)
  ) u_ram (
    .clk     (clk),
    .nrst    (nrst),
    .we      (capture),
    .wr_bank (~front_sel),
    .wr_idx  (idx),
    .wr_data (SRAM_data_in),
    .rd_bank (front_sel),
    .rd_idx  (rd_x[9:5]),
    .rd_data (front_word)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state             <= IDLE;
      idx               <= '0;
      front_sel         <= 1'b0;
      word_address_dest <= '0;
      byte_select       <= 4'h0;
      data_en           <= 1'b0;
      fetch_busy        <= 1'b0;
      fetch_done        <= 1'b0;
      underrun          <= 1'b0;
      bad_row           <= 1'b0;
    end else begin
      fetch_done <= 1'b0;
      bad_row    <= 1'b0;

      if (swap) begin
        front_sel <= ~front_sel;
      end

      case (state)
        IDLE: begin
          if (fetch_start) begin
            if (int'(fetch_row) < LINES) begin
              state             <= FETCH;
              idx               <= '0;
              data_en           <= 1'b1;
              byte_select       <= 4'hF;
              fetch_busy        <= 1'b1;
              word_address_dest <= BASE_ADDR + (32'(fetch_row) * 32'(WORDS_PER_LINE));
            end else begin
              bad_row <= 1'b1;
            end
          end
        end

        FETCH: begin
          if (swap) begin
            state             <= IDLE;
            idx               <= '0;
            data_en           <= 1'b0;
            byte_select       <= 4'h0;
            fetch_busy        <= 1'b0;
            word_address_dest <= '0;
            underrun          <= 1'b1;
          end else if (capture) begin
            if (last_word) begin
              state             <= IDLE;
              idx               <= '0;
              data_en           <= 1'b0;
              byte_select       <= 4'h0;
              fetch_busy        <= 1'b0;
              word_address_dest <= '0;
              fetch_done        <= 1'b1;
            end else begin
              idx               <= idx + 1'b1;
              word_address_dest <= word_address_dest + 32'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Pixel read uses the pre-edge front_sel, so a swap shows up one cycle later.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pixel_data <= 1'b0;
    end else begin
      pixel_data <= (rd_en && (rd_x < 10'(H_ACTIVE))) ? front_word[rd_x[4:0]] : 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_line_prefetch.sv
// Scoreboard bench for vga_line_prefetch with a stalling SRAM responder and a
// bench-side model of both line buffers.
module tb_vga_line_prefetch;

  localparam int WPL = 20;

  logic        tb_clk = 1'b0;
  logic        nrst = 1'b1;
  logic        fetch_start = 1'b0;
  logic [8:0]  fetch_row = '0;
  logic        swap = 1'b0;
  logic        rd_en = 1'b0;
  logic [9:0]  rd_x = '0;
  logic [31:0] SRAM_data_in;
  logic        SRAM_busy = 1'b0;
  logic [31:0] word_address_dest;
  logic [3:0]  byte_select;
  logic        data_en;
  logic        pixel_data;
  logic        fetch_busy;
  logic        fetch_done;
  logic        underrun;
  logic        bad_row;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] addr_q[$];
  logic        pix_q[$];
  logic [31:0] model_bank [2][WPL];
  int          model_front = 0;

  int          stall_n = 0;
  int          stall_cnt = 0;
  logic        prev_en = 1'b0;
  logic [31:0] last_addr = '0;

  always #20 tb_clk = ~tb_clk;

  vga_line_prefetch #(
    .BASE_ADDR      (32'd0),
    .WORDS_PER_LINE (WPL),
    .LINES          (480)
  ) dut (
    .clk               (tb_clk),
    .nrst              (nrst),
    .fetch_start       (fetch_start),
    .fetch_row         (fetch_row),
    .swap              (swap),
    .rd_en             (rd_en),
    .rd_x              (rd_x),
    .SRAM_data_in      (SRAM_data_in),
    .SRAM_busy         (SRAM_busy),
    .word_address_dest (word_address_dest),
    .byte_select       (byte_select),
    .data_en           (data_en),
    .pixel_data        (pixel_data),
    .fetch_busy        (fetch_busy),
    .fetch_done        (fetch_done),
    .underrun          (underrun),
    .bad_row           (bad_row)
  );

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h0000_0005;
    if (a >= 32'd40 && a < 32'd60) return a - 32'd40;
    return (a * 32'h9E37_79B1) ^ 32'h0000_00A5;
  endfunction

  assign SRAM_data_in = sram_word(word_address_dest);

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SRAM responder: busy for stall_n cycles on each new address, then one ready
  // cycle; the address seen on each ready cycle is checked against the queue.
  always @(negedge tb_clk) begin
    if (data_en && (!prev_en || word_address_dest != last_addr)) stall_cnt = 0;
    else stall_cnt++;
    prev_en   = data_en;
    last_addr = word_address_dest;
    SRAM_busy = data_en && (stall_cnt < stall_n);
    if (nrst && data_en && !SRAM_busy) begin
      if (addr_q.size() == 0) check_output("addr_extra", word_address_dest, 32'hFFFF_FFFF);
      else check_output("addr", word_address_dest, addr_q.pop_front());
    end
  end

  function automatic logic model_pixel(input int x, input logic en);
    logic [31:0] w;
    if (!en || x >= 640) return 1'b0;
    w = model_bank[model_front][x / 32];
    return w[x % 32];
  endfunction

  task automatic clear_model();
    for (int b = 0; b < 2; b++)
      for (int w = 0; w < WPL; w++) model_bank[b][w] = '0;
    model_front = 0;
  endtask

  task automatic read_pixel(input string tag, input int x, input logic en);
    rd_en = en;
    rd_x  = 10'(x);
    pix_q.push_back(model_pixel(x, en));
    @(negedge tb_clk);
    rd_en = 1'b0;
    check_output(tag, 32'(pixel_data), 32'(pix_q.pop_front()));
  endtask

  task automatic do_swap();
    swap = 1'b1;
    model_front ^= 1;
    @(negedge tb_clk);
    swap = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_addr"}, word_address_dest, 32'd0);
    check_output({tag, "_ctl"},
                 32'({byte_select, data_en, pixel_data, fetch_busy, fetch_done, underrun, bad_row}), 32'd0);
  endtask

  task automatic applyStimulus(input int row, input int stall, input logic with_swap, input logic poke);
    int n;
    bit seen;
    stall_n     = stall;
    fetch_row   = 9'(row);
    fetch_start = 1'b1;
    if (with_swap) begin
      swap = 1'b1;
      model_front ^= 1;
    end
    for (int k = 0; k < WPL; k++) addr_q.push_back(32'(row * WPL + k));
    @(negedge tb_clk);
    fetch_start = 1'b0;
    swap        = 1'b0;
    check_output("start_ctl", 32'({fetch_busy, data_en, byte_select}), 32'h3F);
    n = 0;
    seen = 0;
    while (!seen && n < 400) begin
      if (poke && n == 6) begin
        fetch_start = 1'b1;
        fetch_row   = 9'd0;
      end else begin
        fetch_start = 1'b0;
      end
      @(negedge tb_clk);
      n++;
      if (fetch_done) seen = 1;
    end
    fetch_start = 1'b0;
    check_output("done_latency", 32'(n), 32'(WPL * (stall + 1)));
    @(negedge tb_clk);
    check_output("done_pulse", 32'({fetch_done, data_en, fetch_busy, byte_select}), 32'd0);
    check_output("addr_q_empty", 32'(addr_q.size()), 32'd0);
    addr_q.delete();
    for (int k = 0; k < WPL; k++) model_bank[model_front ^ 1][k] = sram_word(32'(row * WPL + k));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int done_seen;
    clear_model();
    #5 nrst = 1'b0;
    #1 check_idle_outputs("reset0");
    repeat (2) @(negedge tb_clk);
    nrst = 1'b1;
    @(negedge tb_clk);

    // Reset in the middle of a fetch of row 2.
    stall_n = 0;
    fetch_row = 9'd2;
    fetch_start = 1'b1;
    for (int k = 0; k < WPL; k++) addr_q.push_back(32'(2 * WPL + k));
    @(negedge tb_clk);
    fetch_start = 1'b0;
    repeat (5) @(negedge tb_clk);
    nrst = 1'b0;
    #1 check_idle_outputs("reset_mid");
    addr_q.delete();
    clear_model();
    @(negedge tb_clk);
    nrst = 1'b1;
    @(negedge tb_clk);
    for (int x = 0; x < 640; x++) read_pixel("clr_front", x, 1'b1);
    do_swap();
    for (int x = 0; x < 192; x++) read_pixel("clr_back", x, 1'b1);

    // Unstalled fetch of row 2, with an ignored fetch_start mid-way.
    applyStimulus(2, 0, 1'b0, 1'b1);
    do_swap();
    read_pixel("row2_x32", 32, 1'b1);
    read_pixel("row2_x0", 0, 1'b1);
    read_pixel("row2_x65", 65, 1'b1);
    check_output("row2_x32_abs", 32'(model_pixel(32, 1'b1)), 32'd1);

    // Stalled fetch of the same row into the other bank.
    applyStimulus(2, 3, 1'b0, 1'b0);
    do_swap();
    for (int x = 0; x < 640; x++) read_pixel("stall_scan", x, 1'b1);

    // Pixel bit ordering from row 0 word 0 = 5.
    applyStimulus(0, 0, 1'b0, 1'b0);
    do_swap();
    read_pixel("map_x0", 0, 1'b1);
    read_pixel("map_x1", 1, 1'b1);
    read_pixel("map_x2", 2, 1'b1);
    read_pixel("map_x700", 700, 1'b1);
    read_pixel("map_rden0", 0, 1'b0);

    // Out-of-range row.
    fetch_row = 9'd480;
    fetch_start = 1'b1;
    @(negedge tb_clk);
    fetch_start = 1'b0;
    check_output("bad_row_pulse", 32'({bad_row, data_en, fetch_busy}), 32'h4);
    @(negedge tb_clk);
    check_output("bad_row_clear", 32'({bad_row, data_en, fetch_busy}), 32'h0);

    // Swap and fetch_start together: fetch lands in the old front bank.
    applyStimulus(2, 0, 1'b1, 1'b0);
    do_swap();
    read_pixel("sf_x0", 0, 1'b1);
    read_pixel("sf_x32", 32, 1'b1);
    check_output("sf_x0_abs", 32'(model_pixel(0, 1'b1)), 32'd0);
    check_output("underrun_idle", 32'(underrun), 32'd0);

    // Swap five cycles into a fetch.
    stall_n = 0;
    fetch_row = 9'd2;
    fetch_start = 1'b1;
    for (int k = 0; k < WPL; k++) addr_q.push_back(32'(2 * WPL + k));
    @(negedge tb_clk);
    fetch_start = 1'b0;
    repeat (4) @(negedge tb_clk);
    swap = 1'b1;
    @(negedge tb_clk);
    swap = 1'b0;
    check_output("abort_ctl", 32'({data_en, fetch_busy, byte_select}), 32'd0);
    check_output("underrun_set", 32'(underrun), 32'd1);
    addr_q.delete();
    done_seen = 0;
    repeat (30) begin
      @(negedge tb_clk);
      if (fetch_done) done_seen++;
    end
    check_output("abort_no_done", 32'(done_seen), 32'd0);
    check_output("underrun_sticky", 32'(underrun), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_line_prefetch.md
Name: vga_line_prefetch

Overview:
- Upstream neighbour of VGA_out: streams 1-bit-per-pixel framebuffer rows out of SRAM into a ping-pong pair of on-chip line buffers.
- While the front buffer feeds pixel_data for the row being scanned, the back buffer fills with the next row over the shared SRAM read handshake (word_address_dest / data_en / SRAM_busy / SRAM_data_in).
- The timing controller issues fetch_start during blanking and swap at the line boundary, so the SRAM is never on the pixel critical path.

Parameters:
- BASE_ADDR, 32'd0, word address of framebuffer row 0.
- WORDS_PER_LINE, 20, 32-bit words per row (640 px / 32).
- LINES, 480, number of valid rows.

Ports:
- clk  in  1  system clock (25 MHz pixel clock).
- nrst  in  1  asynchronous reset, active low.
- fetch_start  in  1  one-cycle pulse: begin fetching row fetch_row into the back buffer.
- fetch_row  in  9  row index, sampled with fetch_start.
- swap  in  1  one-cycle pulse: exchange the front and back buffers.
- rd_en  in  1  pixel read enable (h and v both active).
- rd_x  in  10  pixel column, 0..639.
- SRAM_data_in  in  32  read data from SRAM.
- SRAM_busy  in  1  high = current read not complete.
- word_address_dest  out  32  SRAM word address.
- byte_select  out  4  4'b1111 while fetching, else 4'b0000.
- data_en  out  1  SRAM read request.
- pixel_data  out  1  pixel bit, registered.
- fetch_busy  out  1  high while in FETCH.
- fetch_done  out  1  one-cycle pulse after the last word is captured.
- underrun  out  1  sticky: swap arrived while a fetch was in progress.
- bad_row  out  1  one-cycle pulse: fetch_start with fetch_row >= LINES.

Behaviour:
- Reset (asynchronous, nrst low):
  - state = IDLE, word index = 0, front_sel = 0.
  - Both buffers are cleared to 0.
  - All outputs are 0, including word_address_dest and byte_select.
- FSM states: IDLE, FETCH. All outputs are registered.
- IDLE -> FETCH:
  - Taken on a posedge with fetch_start = 1 and fetch_row < LINES.
  - At that edge the block latches the row, sets idx = 0, data_en = 1, byte_select = 4'hF, fetch_busy = 1.
- Address:
  - word_address_dest = BASE_ADDR + row*WORDS_PER_LINE + idx.
  - Computed in 32 bits; the value is held while SRAM_busy = 1.
- Word capture:
  - Occurs at any posedge in FETCH with data_en = 1 and SRAM_busy = 0.
  - SRAM_data_in is written to back[idx], then idx increments.
- Fetch completion:
  - Happens at the capture of idx = WORDS_PER_LINE-1.
  - At that edge: state -> IDLE; data_en, byte_select and fetch_busy clear; fetch_done = 1 for exactly one cycle.
- Fetch latency with SRAM_busy held low:
  - fetch_start sampled at edge 0; captures at edges 1..20; fetch_done high between edges 20 and 21.
  - Each busy cycle adds one cycle.
- fetch_start while in FETCH: ignored; the current fetch is unaffected.
- fetch_start with fetch_row >= LINES: no fetch; bad_row pulses for one cycle; state stays IDLE.
- swap in IDLE: front_sel toggles at the edge.
- swap in FETCH:
  - front_sel toggles.
  - The fetch aborts: state -> IDLE, data_en and fetch_busy clear at that edge, no fetch_done.
  - underrun sets and stays set until reset.
- swap and fetch_start in the same IDLE cycle: swap first; the fetch targets the new back buffer.
- Pixel path (one-cycle latency):
  - pixel_data(t+1) = rd_en(t) && rd_x(t) < 640 ? front[rd_x[9:5]][rd_x[4:0]] : 0.
  - Bit 0 of each word is the leftmost pixel.
- A swap at edge t affects pixel_data from edge t+1 onward (the read at edge t uses the old front buffer).
- Reads of the front buffer are never disturbed by back-buffer writes.

Decomposition:
- Package vga_pkg holds:
  - H_ACTIVE = 640, V_ACTIVE = 480, WORDS_PER_LINE = 20.
  - enum prefetch_state_t {IDLE, FETCH}.
- Sub-module vga_line_ram:
  - 2 x WORDS_PER_LINE x 32 register file, asynchronous active-low clear.
  - One synchronous write port (bank, idx, data, we).
  - One combinational read port (bank, idx).
  - bit select is done in the parent.

Test Plan:
- Reset check:
  - Stimulus: assert nrst low mid-fetch (SRAM_busy = 0).
  - Required: all outputs 0 immediately; after release, state IDLE and pixel_data = 0 for every rd_x.
- Fetch, no stalls:
  - Stimulus: memory[40+k] = k; fetch_start with row 2, SRAM_busy = 0.
  - Required: addresses 40..59 on consecutive cycles; fetch_done exactly 20 cycles after start.
  - Then swap, rd_x = 32 -> pixel_data = 1 one cycle later.
- Stalled fetch:
  - Stimulus: SRAM_busy high for 3 cycles on every word.
  - Required: each address held 4 cycles; fetch_done at cycle 80; buffer contents identical to the no-stall case.
- Pixel map:
  - Stimulus: word0 = 32'h0000_0005.
  - Required: rd_x 0,1,2 -> 1,0,1.
  - rd_x = 700 -> 0; rd_en = 0 -> 0.
- Underrun:
  - Stimulus: swap 5 cycles into a fetch.
  - Required: data_en drops at that edge, no fetch_done, underrun = 1 and stays 1.
- Boundaries:
  - Stimulus: fetch_row = 480.
  - Required: bad_row pulses and data_en stays 0.
  - Stimulus: swap + fetch_start in the same cycle.
  - Required: the fetch lands in the old front bank.
